// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, widths,
// run/halt state encoding and the packed control-strobe bundle.
package cpu_pkg;

    localparam int STEP_W = 3;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

    typedef enum logic {
        EXEC = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic illegal;
        logic ba_out;
        logic r_out;
        logic r_in;
        logic grc;
        logic grb;
        logic gra;
        logic outport_in;
        logic inport_out;
        logic con_in;
        logic lo_out;
        logic hi_out;
        logic lo_in;
        logic hi_in;
        logic c_out;
        logic z_hi_out;
        logic z_lo_out;
        logic z_in;
        logic y_in;
        logic ir_in;
        logic write;
        logic read;
        logic mdr_out;
        logic mdr_in;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic pc_out;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control unit and the datapath: IR/condition/stop in,
// every per-cycle strobe plus run/step/illegal status out.
interface control_sequencer_if;
    import cpu_pkg::*;

    logic [31:0]       ir;
    logic              con_ff;
    logic              stop;
    logic              run;
    logic              illegal;
    logic [STEP_W-1:0] step;
    logic [OP_W-1:0]   alu_op;
    logic pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, read, write;
    logic ir_in, y_in, z_in, z_lo_out, z_hi_out, c_out;
    logic hi_in, lo_in, hi_out, lo_out, con_in, inport_out, outport_in;
    logic gra, grb, grc, r_in, r_out, ba_out;

    modport master (
        input  ir, con_ff, stop,
        output run, illegal, step, alu_op,
        output pc_out, pc_in, inc_pc,
        output mar_in, mdr_in, mdr_out, read, write,
        output ir_in, y_in, z_in, z_lo_out, z_hi_out, c_out,
        output hi_in, lo_in, hi_out, lo_out, con_in, inport_out, outport_in,
        output gra, grb, grc, r_in, r_out, ba_out
    );

    modport slave (
        output ir, con_ff, stop,
        input  run, illegal, step, alu_op,
        input  pc_out, pc_in, inc_pc,
        input  mar_in, mdr_in, mdr_out, read, write,
        input  ir_in, y_in, z_in, z_lo_out, z_hi_out, c_out,
        input  hi_in, lo_in, hi_out, lo_out, con_in, inport_out, outport_in,
        input  gra, grb, grc, r_in, r_out, ba_out
    );

endinterface

// File: rtl/control_sequencer_decode.sv
// Purely combinational microcode table: (opcode, T-step, con_ff) to the
// strobe bundle, ALU operation and an end-of-instruction flag.
module control_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]   opcode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              con_ff_i,
    output ctrl_t             ctrl_o,
    output logic [OP_W-1:0]   alu_op_o,
    output logic              last_step_o
);

    // Fetch occupies T0-T2 for every opcode; execute steps follow by opcode class.
    always_comb begin
        ctrl_o      = '0;
        alu_op_o    = '0;
        last_step_o = 1'b0;
        case (step_i)
            3'd0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1;
                ctrl_o.z_in   = 1'b1;
            end
            3'd1: begin
                ctrl_o.z_lo_out = 1'b1;
                ctrl_o.pc_in    = 1'b1;
                ctrl_o.read     = 1'b1;
                ctrl_o.mdr_in   = 1'b1;
            end
            3'd2: begin
                ctrl_o.mdr_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
                last_step_o    = (opcode_i == OP_NOP);
            end
            default: begin
                case (opcode_i) inside
                    [OP_ADD:OP_SHL], [OP_ADDI:OP_ORI]: begin
                        case (step_i)
                            3'd3: begin
                                ctrl_o.grb   = 1'b1;
                                ctrl_o.r_out = 1'b1;
                                ctrl_o.y_in  = 1'b1;
                            end
                            3'd4: begin
                                if (opcode_i inside {[OP_ADD:OP_SHL]}) begin
                                    ctrl_o.grc   = 1'b1;
                                    ctrl_o.r_out = 1'b1;
                                end else begin
                                    ctrl_o.c_out = 1'b1;
                                end
                                ctrl_o.z_in = 1'b1;
                                alu_op_o    = opcode_i;
                            end
                            3'd5: begin
                                ctrl_o.z_lo_out = 1'b1;
                                ctrl_o.gra      = 1'b1;
                                ctrl_o.r_in     = 1'b1;
                                last_step_o     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        case (step_i)
                            3'd3: begin
                                ctrl_o.grb    = 1'b1;
                                ctrl_o.ba_out = 1'b1;
                                ctrl_o.y_in   = 1'b1;
                            end
                            3'd4: begin
                                ctrl_o.c_out = 1'b1;
                                ctrl_o.z_in  = 1'b1;
                                alu_op_o     = ALU_ADD;
                            end
                            3'd5: begin
                                ctrl_o.z_lo_out = 1'b1;
                                if (opcode_i == OP_LDI) begin
                                    ctrl_o.gra  = 1'b1;
                                    ctrl_o.r_in = 1'b1;
                                    last_step_o = 1'b1;
                                end else begin
                                    ctrl_o.mar_in = 1'b1;
                                end
                            end
                            3'd6: begin
                                ctrl_o.mdr_in = 1'b1;
                                if (opcode_i == OP_ST) begin
                                    ctrl_o.gra   = 1'b1;
                                    ctrl_o.r_out = 1'b1;
                                end else begin
                                    ctrl_o.read = 1'b1;
                                end
                            end
                            default: begin
                                if (opcode_i == OP_ST) begin
                                    ctrl_o.write = 1'b1;
                                end else begin
                                    ctrl_o.mdr_out = 1'b1;
                                    ctrl_o.gra     = 1'b1;
                                    ctrl_o.r_in    = 1'b1;
                                end
                                last_step_o = 1'b1;
                            end
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (step_i)
                            3'd3: begin
                                ctrl_o.gra   = 1'b1;
                                ctrl_o.r_out = 1'b1;
                                ctrl_o.y_in  = 1'b1;
                            end
                            3'd4: begin
                                ctrl_o.grb   = 1'b1;
                                ctrl_o.r_out = 1'b1;
                                ctrl_o.z_in  = 1'b1;
                                alu_op_o     = opcode_i;
                            end
                            3'd5: begin
                                ctrl_o.z_lo_out = 1'b1;
                                ctrl_o.lo_in    = 1'b1;
                            end
                            3'd6: begin
                                ctrl_o.z_hi_out = 1'b1;
                                ctrl_o.hi_in    = 1'b1;
                                last_step_o     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        if (step_i == 3'd3) begin
                            ctrl_o.grb   = 1'b1;
                            ctrl_o.r_out = 1'b1;
                            ctrl_o.z_in  = 1'b1;
                            alu_op_o     = opcode_i;
                        end else if (step_i == 3'd4) begin
                            ctrl_o.z_lo_out = 1'b1;
                            ctrl_o.gra      = 1'b1;
                            ctrl_o.r_in     = 1'b1;
                            last_step_o     = 1'b1;
                        end
                    end
                    OP_BR: begin
                        case (step_i)
                            3'd3: begin
                                ctrl_o.gra    = 1'b1;
                                ctrl_o.r_out  = 1'b1;
                                ctrl_o.con_in = 1'b1;
                            end
                            3'd4: begin
                                ctrl_o.pc_out = 1'b1;
                                ctrl_o.y_in   = 1'b1;
                            end
                            3'd5: begin
                                ctrl_o.c_out = 1'b1;
                                ctrl_o.z_in  = 1'b1;
                                alu_op_o     = ALU_ADD;
                            end
                            3'd6: begin
                                ctrl_o.z_lo_out = 1'b1;
                                ctrl_o.pc_in    = con_ff_i;
                                last_step_o     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: begin
                        if (step_i == 3'd3) begin
                            ctrl_o.gra        = 1'b1;
                            ctrl_o.pc_in      = (opcode_i == OP_JR);
                            ctrl_o.r_out      = (opcode_i == OP_JR) || (opcode_i == OP_OUT);
                            ctrl_o.outport_in = (opcode_i == OP_OUT);
                            ctrl_o.inport_out = (opcode_i == OP_IN);
                            ctrl_o.hi_out     = (opcode_i == OP_MFHI);
                            ctrl_o.lo_out     = (opcode_i == OP_MFLO);
                            ctrl_o.r_in       = (opcode_i == OP_IN) || (opcode_i == OP_MFHI)
                                             || (opcode_i == OP_MFLO);
                            last_step_o       = 1'b1;
                        end
                    end
                    OP_NOP, OP_HALT: begin
                        last_step_o = (step_i == 3'd3);
                    end
                    default: begin
                        if (step_i == 3'd3) begin
                            ctrl_o.illegal = 1'b1;
                            last_step_o    = 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC control unit: owns the T-step counter and run/halt state and
// gates the decoded strobes onto the datapath bundle.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic clock,
    input  logic reset,
    control_sequencer_if.master bus
);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [OP_W-1:0]   opcode;
    ctrl_t             decCtrl;
    ctrl_t             gated;
    logic [OP_W-1:0]   decAlu;
    logic              decLast;
    logic              active;
    logic              unusedIrBits;

    assign opcode       = bus.ir[31:27];
    assign unusedIrBits = ^bus.ir[26:0];

    control_decode u_decode (
        .opcode_i    (opcode),
        .step_i      (step_q),
        .con_ff_i    (bus.con_ff),
        .ctrl_o      (decCtrl),
        .alu_op_o    (decAlu),
        .last_step_o (decLast)
    );

    // Advance the step each cycle; the final step wraps to T0 and decides run vs halt.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (state_q == EXEC) begin
            if (decLast) begin
                step_d = '0;
                if ((opcode == OP_HALT) || bus.stop) begin
                    state_d = HALT;
                end
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end else begin
            step_d = '0;
        end
    end

    // State register; reset aborts any instruction in flight and restarts at T0 fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EXEC;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    assign active = (state_q == EXEC) && !reset;
    assign gated  = active ? decCtrl : '0;

    assign bus.run        = (state_q == EXEC);
    assign bus.step       = step_q;
    assign bus.alu_op     = active ? decAlu : '0;
    assign bus.illegal    = gated.illegal;
    assign bus.pc_out     = gated.pc_out;
    assign bus.pc_in      = gated.pc_in;
    assign bus.inc_pc     = gated.inc_pc;
    assign bus.mar_in     = gated.mar_in;
    assign bus.mdr_in     = gated.mdr_in;
    assign bus.mdr_out    = gated.mdr_out;
    assign bus.read       = gated.read;
    assign bus.write      = gated.write;
    assign bus.ir_in      = gated.ir_in;
    assign bus.y_in       = gated.y_in;
    assign bus.z_in       = gated.z_in;
    assign bus.z_lo_out   = gated.z_lo_out;
    assign bus.z_hi_out   = gated.z_hi_out;
    assign bus.c_out      = gated.c_out;
    assign bus.hi_in      = gated.hi_in;
    assign bus.lo_in      = gated.lo_in;
    assign bus.hi_out     = gated.hi_out;
    assign bus.lo_out     = gated.lo_out;
    assign bus.con_in     = gated.con_in;
    assign bus.inport_out = gated.inport_out;
    assign bus.outport_in = gated.outport_in;
    assign bus.gra        = gated.gra;
    assign bus.grb        = gated.grb;
    assign bus.grc        = gated.grc;
    assign bus.r_in       = gated.r_in;
    assign bus.r_out      = gated.r_out;
    assign bus.ba_out     = gated.ba_out;

endmodule
